// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: forwarding selects, stall/flush, long-latency busy scoreboard.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int FWD_STAGES  = 3,
  parameter int MAX_PENDING = 4,
  parameter int RW = $clog2(NUM_REGS),
  parameter int FW = $clog2(FWD_STAGES + 1),
  parameter int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [RW-1:0]            rs1_d,
  input  logic [RW-1:0]            rs2_d,
  input  logic [RW-1:0]            rd_d,
  input  logic                     issue_valid_d,
  input  logic                     regwrite_d,
  input  logic                     long_d,
  input  logic [FWD_STAGES*RW-1:0] rd_s,
  input  logic [FWD_STAGES-1:0]    regwrite_s,
  input  logic [FWD_STAGES-1:0]    ready_s,
  input  logic                     long_done,
  input  logic [RW-1:0]            long_rd,
  input  logic                     flushflag,
  output logic                     stall_f,
  output logic                     stall_d,
  output logic                     flush_d,
  output logic                     flush_e,
  output logic                     flush_m,
  output logic [FW-1:0]            forwarda_d,
  output logic [FW-1:0]            forwardb_d,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [PW-1:0]            pending_cnt,
  output logic [3:0]               hazard_cause
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              flush_cycles
`endif
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [PW-1:0]       pend_q, pend_d;

  logic [FW-1:0] fwd_a, fwd_b;
  logic          match_a, match_b, rdy_a, rdy_b;
  logic          not_ready, busy_raw, waw, struct_full, hz;
  logic          done_eff, accept;

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    fwd_a   = '0;
    fwd_b   = '0;
    match_a = 1'b0;
    match_b = 1'b0;
    rdy_a   = 1'b0;
    rdy_b   = 1'b0;
    for (int s = FWD_STAGES - 1; s >= 0; s--) begin
      if (regwrite_s[s] && (rs1_d != '0) && (rd_s[s*RW +: RW] == rs1_d)) begin
        fwd_a   = FW'(s + 1);
        match_a = 1'b1;
        rdy_a   = ready_s[s];
      end
      if (regwrite_s[s] && (rs2_d != '0) && (rd_s[s*RW +: RW] == rs2_d)) begin
        fwd_b   = FW'(s + 1);
        match_b = 1'b1;
        rdy_b   = ready_s[s];
      end
    end
  end

  // Ignored retirements must not let the count drift or unblock struct_full.
  assign done_eff = long_done && (pend_q != '0) && busy_q[long_rd];

  always_comb begin
    not_ready   = issue_valid_d && ((match_a && !rdy_a) || (match_b && !rdy_b));
    busy_raw    = issue_valid_d &&
                  (((rs1_d != '0) && busy_q[rs1_d] && !match_a) ||
                   ((rs2_d != '0) && busy_q[rs2_d] && !match_b));
    waw         = issue_valid_d && regwrite_d && (rd_d != '0) && busy_q[rd_d];
    struct_full = issue_valid_d && long_d && (pend_q == PW'(MAX_PENDING)) && !done_eff;
    hz          = not_ready || busy_raw || waw || struct_full;
  end

  assign accept = start && issue_valid_d && long_d && regwrite_d && (rd_d != '0) &&
                  !hz && !flushflag;

  always_comb begin
    busy_d = busy_q;
    if (done_eff) busy_d[long_rd] = 1'b0;
    if (accept)   busy_d[rd_d]    = 1'b1;
    pend_d = pend_q + PW'(accept) - PW'(done_eff);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    stall_f      = start && hz && !flushflag;
    stall_d      = start && hz && !flushflag;
    flush_e      = start && (hz || flushflag);
    flush_d      = start && flushflag;
    flush_m      = start && flushflag;
    forwarda_d   = start ? fwd_a : '0;
    forwardb_d   = start ? fwd_b : '0;
    busy_vec     = start ? busy_q : '0;
    pending_cnt  = start ? pend_q : '0;
    hazard_cause = start ? {struct_full, waw, busy_raw, not_ready} : 4'b0;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (start && flushflag && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = start ? stall_cnt_q : '0;
  assign flush_cycles = start ? flush_cnt_q : '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters (32 regs, 3 stages, 4 pending).
module tb_hazard_scoreboard;

  localparam int RW = 5;
  localparam int NS = 3;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [RW-1:0]  rs1_d, rs2_d, rd_d, long_rd;
  logic           issue_valid_d, regwrite_d, long_d, long_done, flushflag;
  logic [NS*RW-1:0] rd_s;
  logic [NS-1:0]  regwrite_s, ready_s;
  logic           stall_f, stall_d, flush_d, flush_e, flush_m;
  logic [1:0]     forwarda_d, forwardb_d;
  logic [31:0]    busy_vec;
  logic [2:0]     pending_cnt;
  logic [3:0]     hazard_cause;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]    stall_cycles, flush_cycles;
`endif

  int total = 0;
  int bad   = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .start(start),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .issue_valid_d(issue_valid_d), .regwrite_d(regwrite_d), .long_d(long_d),
    .rd_s(rd_s), .regwrite_s(regwrite_s), .ready_s(ready_s),
    .long_done(long_done), .long_rd(long_rd), .flushflag(flushflag),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .flush_m(flush_m), .forwarda_d(forwarda_d), .forwardb_d(forwardb_d),
    .busy_vec(busy_vec), .pending_cnt(pending_cnt), .hazard_cause(hazard_cause)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then leave time for the next input set to settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    start = 1'b1; reset = 1'b0;
    rs1_d = '0; rs2_d = '0; rd_d = '0; long_rd = '0;
    issue_valid_d = 1'b0; regwrite_d = 1'b0; long_d = 1'b0;
    long_done = 1'b0; flushflag = 1'b0;
    rd_s = '0; regwrite_s = '0; ready_s = '0;
  endtask

  task automatic issue_long(input logic [RW-1:0] rd);
    idle();
    issue_valid_d = 1'b1; regwrite_d = 1'b1; long_d = 1'b1; rd_d = rd;
    #1;
    chk("accept_no_stall", stall_d, 0);
    step();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_busy", busy_vec, 0);
    chk("rst_pend", pending_cnt, 0);
    chk("rst_stall", {stall_f, stall_d, flush_d, flush_e, flush_m}, 0);
    chk("rst_cause", hazard_cause, 0);

    // Forwarding priority: stages 0 and 2 both write x5
    idle();
    issue_valid_d = 1'b1; rs1_d = 5;
    regwrite_s = 3'b101; ready_s = 3'b111;
    rd_s[0*RW +: RW] = 5; rd_s[2*RW +: RW] = 5;
    #1;
    chk("fwd_prio_a", forwarda_d, 1);
    chk("fwd_prio_stall", stall_d, 0);
    rs1_d = 0; #1;
    chk("fwd_x0", forwarda_d, 0);
    rs2_d = 5; regwrite_s = 3'b100; #1;
    chk("fwd_oldest_b", forwardb_d, 3);

    // Load-use: stage 0 not ready
    step();
    idle();
    issue_valid_d = 1'b1; rs2_d = 7;
    regwrite_s = 3'b001; ready_s = 3'b000; rd_s[0*RW +: RW] = 7;
    #1;
    chk("nr_stall", {stall_f, stall_d}, 2'b11);
    chk("nr_flush", {flush_d, flush_e, flush_m}, 3'b010);
    chk("nr_cause", hazard_cause, 4'b0001);
    issue_valid_d = 1'b0; #1;
    chk("nr_invalid", stall_d, 0);
    issue_valid_d = 1'b1;
    step();
    ready_s = 3'b001; #1;
    chk("nr_release", stall_d, 0);
    chk("nr_fwdb", forwardb_d, 1);
    chk("nr_flush_e_off", flush_e, 0);

    // Scoreboard RAW on x9
    issue_long(9);
    idle();
    issue_valid_d = 1'b1; rs1_d = 9; #1;
    chk("sb_busy", busy_vec, 32'h0000_0200);
    chk("sb_pend", pending_cnt, 1);
    chk("sb_raw_stall", stall_d, 1);
    chk("sb_raw_cause", hazard_cause, 4'b0010);
    step();
    long_done = 1'b1; long_rd = 9; #1;
    chk("sb_done_cycle", stall_d, 1);
    step();
    long_done = 1'b0; #1;
    chk("sb_release", stall_d, 0);
    chk("sb_clear", busy_vec, 0);
    chk("sb_pend0", pending_cnt, 0);

    // Structural cap
    for (int r = 1; r <= 4; r++) issue_long(RW'(r));
    idle(); #1;
    chk("st_pend4", pending_cnt, 4);
    chk("st_busy", busy_vec, 32'h0000_001E);
    issue_valid_d = 1'b1; regwrite_d = 1'b1; long_d = 1'b1; rd_d = 5; #1;
    chk("st_full_stall", stall_d, 1);
    chk("st_full_cause", hazard_cause, 4'b1000);
    long_done = 1'b1; long_rd = 1; #1;
    chk("st_done_same", stall_d, 0);
    step();
    idle(); #1;
    chk("st_pend_keep", pending_cnt, 4);
    chk("st_busy_swap", busy_vec, 32'h0000_003C);

    // WAW on x3, then flush during the stall
    issue_valid_d = 1'b1; regwrite_d = 1'b1; rd_d = 3; #1;
    chk("waw_cause", hazard_cause, 4'b0100);
    chk("waw_stall", stall_d, 1);
    flushflag = 1'b1; #1;
    chk("waw_flush", {flush_d, flush_e, flush_m}, 3'b111);
    chk("waw_flush_stall", stall_d, 0);
    step();
    idle(); #1;
    chk("waw_busy_kept", busy_vec, 32'h0000_003C);

    // Retirement of a non-busy register is ignored
    long_done = 1'b1; long_rd = 10;
    step();
    long_done = 1'b0; #1;
    chk("ign_pend", pending_cnt, 4);

    // start=0 blanks outputs; long_done still retires, accepts suppressed
    start = 1'b0; issue_valid_d = 1'b1; regwrite_d = 1'b1; rd_d = 3; #1;
    chk("st0_outs", {stall_d, flush_e, hazard_cause}, 0);
    chk("st0_busy_out", busy_vec, 0);
    regwrite_d = 1'b1; long_d = 1'b1; rd_d = 12; long_done = 1'b1; long_rd = 2;
    step();
    idle(); #1;
    chk("st0_busy", busy_vec, 32'h0000_0038);
    chk("st0_pend", pending_cnt, 3);

    // Reset with three pending
    reset = 1'b1;
    step();
    reset = 1'b0; #1;
    chk("rst_mid_busy", busy_vec, 0);
    chk("rst_mid_pend", pending_cnt, 0);
    chk("rst_mid_outs", {stall_d, flush_e, forwarda_d, hazard_cause}, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_mid_stallcnt", stall_cycles, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
